// File: rtl/hc_sr04_dist_ascii.sv
// HC-SR04 distance to ASCII: sequential double-dabble into six decimal
// digits, streamed with optional CR LF over a valid/ready byte handshake.
module hc_sr04_dist_ascii #(
   parameter bit EOL_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [18:0] data_i,
   input  logic        data_vld,
   output logic [7:0]  tx_data,
   output logic        tx_vld,
   input  logic        tx_rdy,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      SEND
   } state_t;

   localparam logic [2:0] LAST = EOL_EN ? 3'd7 : 3'd5;

   state_t      state;
   logic [18:0] bin;
   logic [18:0] pend_data;
   logic        pend;
   logic [23:0] bcd;
   logic [4:0]  cnt;
   logic [2:0]  idx;

   logic [23:0] bcd_adj;
   logic [23:0] bcd_nxt;
   logic        hs;

   function automatic logic [23:0] dabble(input logic [23:0] b);
      logic [23:0] r;
      r = b;
      for (int i = 0; i < 6; i++) begin
         if (b[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   // Digits are < 10, so 0x30 + digit is just {0x3, digit}.
   function automatic logic [7:0] ascii_of(
      input logic [2:0]  i,
      input logic [23:0] b
   );
      logic [7:0] r;
      r = 8'h00;
      unique case (i)
         3'd0: r = {4'h3, b[23:20]};
         3'd1: r = {4'h3, b[19:16]};
         3'd2: r = {4'h3, b[15:12]};
         3'd3: r = {4'h3, b[11:8]};
         3'd4: r = {4'h3, b[7:4]};
         3'd5: r = {4'h3, b[3:0]};
         3'd6: r = 8'h0D;
         3'd7: r = 8'h0A;
      endcase
      return r;
   endfunction

   assign bcd_adj = dabble(bcd);
   assign bcd_nxt = (bcd_adj << 1) | {23'd0, bin[18]};
   assign hs      = tx_vld & tx_rdy;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         bin       <= '0;
         pend_data <= '0;
         pend      <= 1'b0;
         bcd       <= '0;
         cnt       <= '0;
         idx       <= '0;
         tx_data   <= 8'h00;
         tx_vld    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               tx_vld <= 1'b0;
               if (data_vld) begin
                  bin   <= data_i;
                  bcd   <= '0;
                  cnt   <= '0;
                  state <= CONV;
               end
            end
            CONV: begin
               bcd <= bcd_nxt;
               bin <= bin << 1;
               cnt <= cnt + 5'd1;
               if (data_vld) begin
                  pend_data <= data_i;
                  pend      <= 1'b1;
               end
               if (cnt == 5'd18) begin
                  state   <= SEND;
                  idx     <= '0;
                  tx_vld  <= 1'b1;
                  tx_data <= ascii_of(3'd0, bcd_nxt);
               end
            end
            SEND: begin
               if (data_vld) begin
                  pend_data <= data_i;
                  pend      <= 1'b1;
               end
               if (hs) begin
                  if (idx == LAST) begin
                     tx_vld  <= 1'b0;
                     tx_data <= 8'h00;
                     bcd     <= '0;
                     cnt     <= '0;
                     idx     <= '0;
                     if (pend) begin
                        bin   <= pend_data;
                        pend  <= data_vld;
                        state <= CONV;
                     end else if (data_vld) begin
                        // Value arriving on the closing edge starts directly.
                        bin   <= data_i;
                        pend  <= 1'b0;
                        state <= CONV;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     idx     <= idx + 3'd1;
                     tx_data <= ascii_of(idx + 3'd1, bcd);
                  end
               end
            end
            default: begin
               state  <= IDLE;
               tx_vld <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/hc_sr04_dist_ascii.md
# hc_sr04_dist_ascii

Downstream stage of the HC-SR04 echo measurement path. Takes the 19-bit distance word produced by the echo driver, converts it to six decimal digits with a sequential double-dabble, and streams the digits plus an optional CR LF to the UART transmitter over a valid/ready byte handshake. It sits between the ultrasonic measurement logic and `uart_tx` in the UART top level.

## Interface
- `EOL_EN`, default 1: when 1, append CR (0x0D) and LF (0x0A) after the digits, for an 8-byte frame. When 0, the frame is the 6 digits only.
- `clk`, input, 1: system clock. This is the only clock.
- `rstn`, input, 1: asynchronous, active-low reset.
- `data_i`, input, 19: distance word, unsigned binary. Sampled only when `data_vld`=1.
- `data_vld`, input, 1: single-cycle pulse that marks a new `data_i`. The sensor top generates it at the falling edge of echo, one cycle after the distance register updates.
- `tx_data`, output, 8: ASCII byte presented to the UART.
- `tx_vld`, output, 1: `tx_data` is valid.
- `tx_rdy`, input, 1: UART accepts the byte. A byte transfers on a rising edge where `tx_vld` and `tx_rdy` are both 1.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, CONV and SEND.
- IDLE:
  - On `data_vld`, load `data_i` into the 19-bit binary shift register, clear the 24-bit BCD register, clear the bit counter, and go to CONV.
- CONV, double-dabble, one bit per cycle:
  - Each cycle, every BCD nibble that is ≥5 gets +3 added.
  - Then {BCD, bin} shifts left by 1.
  - The bit counter counts 0..18. After 19 shifts, the BCD register holds 6 digits, most significant digit in [23:20]. Go to SEND with byte index 0.
- SEND:
  - Byte index 0..5 selects digit 5..0. `tx_data` = 0x30 + digit.
  - Byte index 6 gives 0x0D and index 7 gives 0x0A. These exist only when `EOL_EN`=1.
  - On each handshake, increment the index.
  - On the handshake of the last byte, go to CONV if a pending value exists, otherwise go to IDLE.
- Leading zeros are always sent. The frame length is fixed.
- Pending buffer, one entry deep:
  - A `data_vld` seen in CONV or SEND stores `data_i` into the pending register and sets `pend`.
  - A later `data_vld` overwrites it, so the latest value wins.
  - When leaving SEND for CONV, the pending value is loaded and `pend` is cleared on that same edge.
  - If a new `data_vld` arrives on that same edge, it overwrites the pending register and `pend` stays set.
- Full 19-bit range is supported, 0..524287.
- Arithmetic is unsigned throughout. No value saturates or wraps.

## Timing
- Reset values:
  - `tx_data`=0x00, `tx_vld`=0, `busy`=0.
  - State IDLE, `pend`=0, all shift, BCD and index registers 0.
- Reset mid-operation aborts the frame immediately. `tx_vld` drops asynchronously and no partial frame resumes.
- Latency:
  - `data_vld` is high in cycle N, and the load happens at the end of cycle N.
  - CONV occupies cycles N+1..N+19.
  - `tx_vld`=1 with the first digit from cycle N+20.
- `busy` is 1 from cycle N+1 until the cycle after the last handshake. It stays 1 with no gap when a pending value starts.
- Handshake rules:
  - `tx_vld`, once asserted, stays high until the handshake.
  - `tx_data` is stable while `tx_vld`=1 and `tx_rdy`=0.
  - After a handshake, the next byte appears in the following cycle and `tx_vld` stays 1. There are no idle cycles inside a frame.
- Throughput:
  - With `tx_rdy` held at 1, a frame completes in 19 + 8 cycles (`EOL_EN`=1) or 19 + 6 cycles (`EOL_EN`=0) after the load.
  - A pending frame starts CONV on the cycle after the final handshake. `tx_vld` is 0 during that CONV.
- Timing of `tx_rdy` itself is not constrained. If `tx_rdy` is 1 while `tx_vld`=0, nothing happens.

## Test plan
- `data_i`=0 with a `data_vld` pulse and `tx_rdy`=1 → bytes 0x30 ×6, 0x0D, 0x0A. The first `tx_vld` appears exactly 20 cycles after the pulse, and `busy` returns to 0.
- `data_i`=20383 (1199×17, maximum sensor range) → "020383\r\n", i.e. 0x30 0x32 0x30 0x33 0x38 0x33 0x0D 0x0A. Also `data_i`=524287 → "524287\r\n".
- Backpressure: `data_i`=12345, with `tx_rdy` low for 5 cycles at each byte → every byte is held stable with `tx_vld`=1 until accepted. The output is "012345\r\n" with no duplicated or skipped bytes.
- Overlap: pulse 111 during CONV of 999, then pulse 222 during SEND → "000999\r\n" followed immediately by "000222\r\n". The value 111 is never sent.
- Reset asserted during byte 3 of a frame → `tx_vld`=0, `busy`=0 and `tx_data`=0x00 at once. After release, a new pulse with value 7 produces the complete frame "000007\r\n".
- `EOL_EN`=0, `data_i`=42 → exactly 6 bytes, "000042". `busy` falls after the 6th handshake.
